// File: rtl/p2_link_decoder.sv
// rtl/p2_link_decoder.sv - player-2 link RX byte decoder with link watchdog
// Pops one status byte per frame from the UART RX FIFO and unpacks remote flags/position.
module p2_link_decoder #(
   parameter int TIMEOUT_CYCLES = 6500000,
   parameter int CNT_W          = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_empty,
   input  logic [7:0]  r_data,
   output logic        rd_uart,
   output logic [4:0]  d_position,
   output logic        d_position_valid,
   output logic        menu_start,
   output logic        rst_req,
   output logic        scoreboard_key,
   output logic        link_up,
   output logic [15:0] frame_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_POP   = 2'd1;
   localparam logic [1:0] S_APPLY = 2'd2;

   localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       r_state;
   logic [7:0]       r_byte_q;
   logic [CNT_W-1:0] r_wd_cnt;
   logic             r_rd_uart;
   logic [4:0]       r_d_position;
   logic             r_d_position_valid;
   logic             r_menu_start;
   logic             r_rst_req;
   logic             r_scoreboard_key;
   logic             r_link_up;
   logic [15:0]      r_frame_count;

   logic [CNT_W-1:0] w_cnt_next;
   logic             w_timeout;

   assign w_cnt_next = (r_wd_cnt == L_TIMEOUT) ? r_wd_cnt : r_wd_cnt + CNT_W'(1);

   // Only IDLE may drop the flags: a POP always leads into APPLY, which overrides a timeout.
   assign w_timeout = (r_state == S_IDLE) && (w_cnt_next == L_TIMEOUT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state            <= S_IDLE;
         r_byte_q           <= 8'd0;
         r_wd_cnt           <= '0;
         r_rd_uart          <= 1'b0;
         r_d_position       <= 5'd0;
         r_d_position_valid <= 1'b0;
         r_menu_start       <= 1'b0;
         r_rst_req          <= 1'b0;
         r_scoreboard_key   <= 1'b0;
         r_link_up          <= 1'b0;
         r_frame_count      <= 16'd0;
      end else begin
         r_rd_uart          <= 1'b0;
         r_d_position_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_wd_cnt <= w_cnt_next;
               if (w_timeout) begin
                  r_link_up        <= 1'b0;
                  r_menu_start     <= 1'b0;
                  r_rst_req        <= 1'b0;
                  r_scoreboard_key <= 1'b0;
                  r_d_position     <= 5'd0;
               end
               if (!rx_empty) begin
                  r_byte_q  <= r_data;
                  r_rd_uart <= 1'b1;
                  r_state   <= S_POP;
               end
            end
            S_POP: begin
               r_wd_cnt <= w_cnt_next;
               r_state  <= S_APPLY;
            end
            S_APPLY: begin
               r_scoreboard_key   <= r_byte_q[7];
               r_rst_req          <= r_byte_q[6];
               r_menu_start       <= r_byte_q[5];
               r_d_position       <= r_byte_q[4:0];
               r_d_position_valid <= 1'b1;
               r_link_up          <= 1'b1;
               r_frame_count      <= r_frame_count + 16'd1;
               r_wd_cnt           <= '0;
               r_state            <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_uart          = r_rd_uart;
   assign d_position       = r_d_position;
   assign d_position_valid = r_d_position_valid;
   assign menu_start       = r_menu_start;
   assign rst_req          = r_rst_req;
   assign scoreboard_key   = r_scoreboard_key;
   assign link_up          = r_link_up;
   assign frame_count      = r_frame_count;

endmodule

// File: doc/p2_link_decoder.md
Name: p2_link_decoder

Overview:
Receive-side decoder for the inter-board player link. Pops status bytes from the UART RX FIFO (`uart_ff_buf`) one at a time. Each byte is unpacked as {scoreboard_key, rst_req, menu_start, d_position[4:0]}; the block holds the remote player's flags and emits a one-cycle position-increment strobe per byte for the player-2 position accumulator. A link watchdog drops stale remote flags when the peer goes silent. It is the counterpart of the TX-side byte packer feeding the same link.

Parameters:
TIMEOUT_CYCLES, 6500000, clk cycles with no received byte before the link is declared down (100 ms at 65 MHz).
CNT_W, 23, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock (65 MHz domain).
rst  in  1  asynchronous reset, active-low.
rx_empty  in  1  RX FIFO empty flag.
r_data  in  8  RX FIFO head byte; valid whenever rx_empty=0.
rd_uart  out  1  RX FIFO pop strobe, one cycle per byte.
d_position  out  5  last received position increment (unsigned).
d_position_valid  out  1  one-cycle strobe: d_position updated this cycle.
menu_start  out  1  remote menu_start_game flag.
rst_req  out  1  remote reset request.
scoreboard_key  out  1  remote scoreboard key-press flag.
link_up  out  1  1 while bytes arrive within TIMEOUT_CYCLES.
frame_count  out  16  bytes decoded since reset; wraps.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, byte_q=0, every output 0 (link_up=0, rd_uart=0), watchdog counter=0.
- FSM states: IDLE, POP, APPLY.
  - IDLE: if rx_empty=0, set byte_q<=r_data and go to POP; otherwise stay in IDLE.
  - POP: rd_uart=1 for this cycle only; go to APPLY.
  - APPLY: rd_uart=0. Decode byte_q:
    - scoreboard_key<=byte_q[7], rst_req<=byte_q[6], menu_start<=byte_q[5], d_position<=byte_q[4:0].
    - d_position_valid=1 for this cycle.
    - link_up<=1.
    - frame_count<=frame_count+1 (wraps 0xFFFF->0x0000).
    - Watchdog counter<=0.
    - Go to IDLE.
- Throughput: 3 cycles per byte minimum. The extra cycle gives rx_empty time to reflect the pop before IDLE samples it again.
- Latency: a byte present at cycle N (IDLE, rx_empty=0) has decoded outputs visible at cycle N+3.
- rd_uart is never asserted while rx_empty=1 at the IDLE decision point. Exactly one pop occurs per decoded byte; no byte is dropped or duplicated.
- d_position_valid is 0 in every state except APPLY. d_position and the flags hold between bytes.
- Watchdog:
  - The counter increments every cycle when not in APPLY and saturates at TIMEOUT_CYCLES.
  - When the counter reaches TIMEOUT_CYCLES: link_up<=0, menu_start<=0, rst_req<=0, scoreboard_key<=0, d_position<=0. frame_count is held.
- Simultaneous APPLY and timeout: APPLY wins; outputs take the decoded values and the counter clears.
- rst_req is passed through as decoded; no filtering. A byte with bit6=0 deasserts it.
- Reset mid-operation (in POP or APPLY): abort to IDLE immediately. rd_uart and d_position_valid drop asynchronously. The FIFO byte is popped only if the POP-cycle clock edge completed before reset asserted.
- r_data is sampled only in IDLE; changes in other states are ignored.

Test Plan:
1. Reset release, FIFO holds 0xA7: rd_uart pulses exactly once. Three cycles after IDLE sees rx_empty=0: scoreboard_key=1, rst_req=0, menu_start=1, d_position=7, d_position_valid=1 for one cycle, link_up=1, frame_count=1.
2. Burst of 4 bytes 0x21, 0x22, 0x23, 0x3F back-to-back (rx_empty low throughout): 4 rd_uart pulses spaced 3 cycles apart. d_position sequence 1, 2, 3, 31. frame_count=4. menu_start=1 at end.
3. Watchdog with TIMEOUT_CYCLES=50: after byte 0x20, send nothing for 50 cycles. link_up, menu_start, d_position all fall to 0 exactly at counter=50; frame_count stays 1. Next byte 0x20 restores link_up=1.
4. Simultaneity, TIMEOUT_CYCLES=50: time a byte so APPLY lands on the cycle the counter reaches 50. link_up stays 1, flags take the decoded values, counter=0.
5. Reset asserted during POP: outputs go to 0 immediately. After release, the FSM re-reads the FIFO head with a single pop and no duplicate d_position_valid.
6. frame_count wrap: preload via 65536 bytes of 0x00. frame_count wraps to 0, d_position=0, d_position_valid pulses each byte.
